// File: rtl/nmc_writeback.sv
// nmc_writeback: drains ReLU-quantised activation rows into consecutive rows of
// the activation SRAM. A small row FIFO decouples the ReLU handshake from the
// SRAM req/gnt port. The FIFO head sits in a registered output slot that drives
// wb_addr/wb_data directly, so those stay stable until the write is granted.
// Optional feature macro: WB_ZERO_SKIP_EN. When it is defined, all-zero rows are
// retired without an SRAM write, and their address is skipped.
module nmc_writeback #(
  parameter int DATA_W     = 4,
  parameter int DIM        = 64,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       num_rows,
  input  logic                  relu_valid,
  input  logic [DATA_W*DIM-1:0] relu_data,
  output logic                  relu_ready,
  output logic                  wb_req,
  output logic [ADDR_W-1:0]     wb_addr,
  output logic [DATA_W*DIM-1:0] wb_data,
  input  logic                  wb_gnt,
  output logic                  busy,
  output logic                  done
);

  localparam int ROW_W = DATA_W * DIM;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e state_q, state_d;

  // Job bookkeeping: rows requested, rows accepted, rows retired, next address.
  logic [ADDR_W:0]   num_q, acc_q, wr_q;
  logic [ADDR_W-1:0] addr_q;

  // Row storage behind the output slot. The output slot counts toward occupancy,
  // so the memory never holds more than FIFO_DEPTH-1 rows, and equal pointers mean empty.
  logic [ROW_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    occ_q;

  // Output slot holding the current FIFO head.
  logic              head_vld_q;
  logic [ROW_W-1:0]  head_data_q;
`ifdef WB_ZERO_SKIP_EN
  logic              head_zero_q;
`endif

  logic             in_job, job_start, mem_empty;
  logic             push, head_pop, head_skip, head_load, head_fill;
  logic             mem_we, mem_re;
  logic [ROW_W-1:0] src_row;

  assign in_job    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign mem_empty = (wr_ptr_q == rd_ptr_q);

  // A full FIFO refuses a row even when the head is granted in the same cycle.
  assign relu_ready = (state_q == S_RUN) && (occ_q < DEPTH_C) && (acc_q < num_q);
  assign push       = relu_valid && relu_ready;

`ifdef WB_ZERO_SKIP_EN
  assign head_skip = in_job && head_vld_q && head_zero_q;
`else
  assign head_skip = 1'b0;
`endif

  assign wb_req    = in_job && head_vld_q && !head_skip;
  assign head_pop  = (wb_req && wb_gnt) || head_skip;
  assign head_load = !head_vld_q || head_pop;
  // An incoming row goes straight into an empty output slot only when the memory is empty, which keeps rows in order.
  assign head_fill = !mem_empty || push;
  assign src_row   = mem_empty ? relu_data : mem_q[rd_ptr_q];
  assign mem_re    = head_load && !mem_empty;
  assign mem_we    = push && !(mem_empty && head_load);

  assign wb_addr = addr_q;
  assign wb_data = head_data_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

  // Job state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Job sequencing: start, accept until the last row arrives, drain until the last write retires.
  always_comb begin
    state_d   = state_q;
    job_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          job_start = 1'b1;
          state_d   = (num_rows == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (push && (acc_q + CNT_ONE == num_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (head_pop && (wr_q + CNT_ONE == num_q)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch job parameters on start and track accepted/retired rows and the write address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q  <= '0;
      acc_q  <= '0;
      wr_q   <= '0;
      addr_q <= '0;
    end else if (job_start) begin
      num_q  <= num_rows;
      acc_q  <= '0;
      wr_q   <= '0;
      addr_q <= base_addr;
    end else begin
      if (push) acc_q <= acc_q + CNT_ONE;
      if (head_pop) begin
        wr_q   <= wr_q + CNT_ONE;
        addr_q <= addr_q + ADDR_ONE;
      end
    end
  end

  // FIFO pointers and total occupancy (memory plus output slot).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (mem_we) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (mem_re) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push, head_pop})
        2'b10:   occ_q <= occ_q + OCC_ONE;
        2'b01:   occ_q <= occ_q - OCC_ONE;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Row memory write port; the contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= relu_data;
  end

  // Output slot: refill from the memory head, or from the input when the memory is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
    end else if (head_load) begin
      head_vld_q <= head_fill;
      if (head_fill) head_data_q <= src_row;
    end
  end

`ifdef WB_ZERO_SKIP_EN
  // Precompute the all-zero flag when a row enters the output slot, keeping the wide OR off the req path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         head_zero_q <= 1'b0;
    else if (head_load && head_fill) head_zero_q <= ~|src_row;
  end
`endif

endmodule

// File: tb/tb_nmc_writeback.sv
// Bench for nmc_writeback: directed jobs plus a queue-based model of the expected
// SRAM write stream, checked on every falling edge.
module tb_nmc_writeback;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst, start, relu_valid, relu_ready, wb_req, wb_gnt, busy, done;
  logic [7:0]   base_addr, wb_addr;
  logic [8:0]   num_rows;
  logic [255:0] relu_data, wb_data;

  always #5 clk = ~clk;

  nmc_writeback #(.DATA_W(4), .DIM(64), .ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .relu_valid(relu_valid), .relu_data(relu_data), .relu_ready(relu_ready),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .busy(busy), .done(done)
  );

  int nchk = 0, nerr = 0, cyc = 0;
  int done_cnt = 0, busy_cnt = 0, req_cnt = 0, last_gnt_cyc = 0, done_cyc = 0;

  // Model state: the job as described by the spec, plus expected and observed write streams.
  bit           m_idle = 1'b1, m_run = 1'b0, m_done = 1'b0;
  int           m_acc = 0, m_wr = 0, m_num = 0;
  logic [7:0]   m_base = '0;
  logic [7:0]   eq_a[$];
  logic [255:0] eq_d[$];
  logic [7:0]   log_a[$];
  logic [255:0] log_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] row_of(input int tag);
    logic [255:0] r;
    r = '0;
    if (tag != 0)
      for (int i = 0; i < 64; i++) r[4*i +: 4] = 4'((tag * 7 + i * 3 + 1) % 16);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare outputs with the model, then advance the model by the events of the coming edge.
  always @(negedge clk) begin
    bit idle_now, done_now, exp_rdy, rdy;
    if (rst) begin
      chk("rst_ctrl", {wb_req, relu_ready, busy, done, wb_addr}, '0);
      chk("rst_data", wb_data, '0);
      m_idle = 1'b1; m_run = 1'b0; m_done = 1'b0; m_acc = 0; m_wr = 0;
      eq_a.delete(); eq_d.delete();
    end else begin
      exp_rdy = m_run && ((m_acc - m_wr) < DEPTH) && (m_acc < m_num);
      chk("busy", busy, !m_idle);
`ifdef WB_ZERO_SKIP_EN
      rdy = relu_ready;
`else
      chk("done", done, m_done);
      chk("relu_ready", relu_ready, exp_rdy);
      rdy = exp_rdy;
`endif
      if (wb_req) begin
        req_cnt++;
        if (eq_a.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          chk("wb_addr", wb_addr, eq_a[0]);
          chk("wb_data", wb_data, eq_d[0]);
        end
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end

      idle_now = m_idle;
      done_now = m_done;
      if (done_now) begin m_done = 1'b0; m_idle = 1'b1; end
`ifdef WB_ZERO_SKIP_EN
      if (done) begin m_idle = 1'b1; m_run = 1'b0; end
`endif
      if (idle_now && start) begin
        m_idle = 1'b0; m_acc = 0; m_wr = 0; m_num = int'(num_rows); m_base = base_addr;
        if (num_rows == 0) m_done = 1'b1;
        else               m_run  = 1'b1;
      end
      if (relu_valid && rdy) begin
`ifdef WB_ZERO_SKIP_EN
        if (relu_data != '0) begin
          eq_a.push_back(m_base + 8'(m_acc)); eq_d.push_back(relu_data);
        end
`else
        eq_a.push_back(m_base + 8'(m_acc)); eq_d.push_back(relu_data);
`endif
        m_acc++;
        if (m_acc == m_num) m_run = 1'b0;
      end
      if (wb_req && wb_gnt && eq_a.size() != 0) begin
        log_a.push_back(wb_addr); log_d.push_back(wb_data);
        void'(eq_a.pop_front()); void'(eq_d.pop_front());
        m_wr++;
        last_gnt_cyc = cyc;
`ifndef WB_ZERO_SKIP_EN
        if (m_wr == m_num) m_done = 1'b1;
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    start = 1'b1; base_addr = b; num_rows = n;
    step(1);
    start = 1'b0;
  endtask

  task automatic send_rows(input int tag0, input int n, input int maxc, output int sent);
    bit acc;
    sent = 0;
    for (int c = 0; c < maxc && sent < n; c++) begin
      relu_valid = 1'b1;
      relu_data  = row_of(tag0 + sent);
      @(negedge clk);
      acc = relu_ready;
      step(1);
      if (acc) sent++;
    end
    relu_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int d0, c;
    d0 = done_cnt; c = 0;
    while (done_cnt == d0 && c < maxc) begin step(1); c++; end
    chk("done_seen", done_cnt != d0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d0, b0, r0;
    rst = 1'b1; start = 1'b0; relu_valid = 1'b0; relu_data = '0;
    base_addr = '0; num_rows = '0; wb_gnt = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("idle_busy", busy, 0);
    chk("idle_ready", relu_ready, 0);

    // Three rows to 0x10 with the grant tied high.
    log_a.delete(); log_d.delete();
    wb_gnt = 1'b1; d0 = done_cnt;
    do_start(8'h10, 9'd3);
    send_rows(1, 3, 20, s);
    chk("t2_sent", s, 3);
    wait_done(20);
    step(3);
    chk("t2_done_once", done_cnt - d0, 1);
    chk("t2_done_lat", done_cyc - last_gnt_cyc, 1);
    chk("t2_nwrites", log_a.size(), 3);
    if (log_a.size() == 3) begin
      chk("t2_a0", log_a[0], 8'h10); chk("t2_a1", log_a[1], 8'h11); chk("t2_a2", log_a[2], 8'h12);
      chk("t2_d0_lit", log_d[0][15:0], 16'h1eb8);
      chk("t2_d0", log_d[0], row_of(1)); chk("t2_d1", log_d[1], row_of(2)); chk("t2_d2", log_d[2], row_of(3));
    end

    // Address wrap from 0xFE.
    log_a.delete(); log_d.delete();
    do_start(8'hFE, 9'd4);
    send_rows(11, 4, 30, s);
    wait_done(20);
    step(2);
    chk("t3_nwrites", log_a.size(), 4);
    if (log_a.size() == 4) begin
      chk("t3_a0", log_a[0], 8'hFE); chk("t3_a1", log_a[1], 8'hFF);
      chk("t3_a2", log_a[2], 8'h00); chk("t3_a3", log_a[3], 8'h01);
      chk("t3_d3", log_d[3], row_of(14));
    end

    // Back-pressure: grant held low, five rows offered to a four-deep buffer.
    log_a.delete(); log_d.delete();
    wb_gnt = 1'b0;
    do_start(8'h40, 9'd5);
    send_rows(21, 5, 8, s);
    chk("t4_accepts", s, 4);
    chk("t4_ready_low", relu_ready, 0);
    chk("t4_req", wb_req, 1);
    chk("t4_addr", wb_addr, 8'h40);
    chk("t4_data", wb_data, row_of(21));
    step(3);
    chk("t4_req_hold", wb_req, 1);
    chk("t4_addr_hold", wb_addr, 8'h40);
    chk("t4_data_hold", wb_data, row_of(21));
    chk("t4_no_writes", log_a.size(), 0);
    wb_gnt = 1'b1;
    send_rows(25, 1, 20, s);
    chk("t4_last_accept", s, 1);
    wait_done(30);
    step(2);
    chk("t4_nwrites", log_a.size(), 5);
    if (log_a.size() == 5)
      for (int k = 0; k < 5; k++) begin
        chk("t4_addr_k", log_a[k], 8'(8'h40 + k));
        chk("t4_data_k", log_d[k], row_of(21 + k));
      end

    // Empty job.
    d0 = done_cnt; b0 = busy_cnt; r0 = req_cnt;
    do_start(8'h55, 9'd0);
    step(4);
    chk("t5_busy_cycles", busy_cnt - b0, 1);
    chk("t5_done_cycles", done_cnt - d0, 1);
    chk("t5_no_req", req_cnt - r0, 0);

`ifdef WB_ZERO_SKIP_EN
    // Zero row in the middle is skipped but still advances the address.
    log_a.delete(); log_d.delete();
    wb_gnt = 1'b1;
    do_start(8'h20, 9'd3);
    send_rows(41, 1, 20, s);
    send_rows(0, 1, 20, s);
    send_rows(43, 1, 20, s);
    wait_done(30);
    step(2);
    chk("t6_nwrites", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("t6_a0", log_a[0], 8'h20); chk("t6_d0", log_d[0], row_of(41));
      chk("t6_a1", log_a[1], 8'h22); chk("t6_d1", log_d[1], row_of(43));
    end
`endif

    // Asynchronous reset in the middle of a stalled job.
    wb_gnt = 1'b0;
    do_start(8'h30, 9'd6);
    send_rows(31, 3, 10, s);
    chk("t1_mid_req", wb_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_req", wb_req, 0);
    chk("t1_rst_addr", wb_addr, 0);
    chk("t1_rst_data", wb_data, 0);
    chk("t1_rst_ready", relu_ready, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_done", done, 0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("t1_post_ready", relu_ready, 0);
    chk("t1_post_busy", busy, 0);
    chk("t1_post_req", wb_req, 0);

    // A fresh job after reset writes only its own rows.
    log_a.delete(); log_d.delete();
    wb_gnt = 1'b1;
    do_start(8'h70, 9'd2);
    send_rows(51, 2, 20, s);
    wait_done(20);
    step(2);
    chk("t1_new_nwrites", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("t1_new_a0", log_a[0], 8'h70);
      chk("t1_new_d0", log_d[0], row_of(51));
    end
    chk("exp_queue_empty", eq_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
